uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the bidirectional UART path. It oversamples the asynchronous `rx_pin` with the system clock and reassembles LSB-first 8N1 frames (optionally 8E1). Each good word is presented as a parallel word with a one-cycle `data_ready` pulse, a form `uart_tx` accepts directly for loopback/echo. Line errors are reported as one-cycle pulses and are never presented as data.

## Interface
- `DELAY_FRAMES`, 2812: clock cycles per bit (27 MHz / 9600 baud); must be ≥ 4.
- `BIT_PER_WORD`, 7: MSB index of the data word (word width = BIT_PER_WORD+1).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_pin`  in  1  serial line, idle high, asynchronous to `clk`.
- `data`  out  BIT_PER_WORD+1  last good word; held until the next good word.
- `data_ready`  out  1  one-cycle pulse when `data` updates.
- `framing_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (only with parity enabled).
- `busy`  out  1  high from start detection until return to IDLE.

## Operation
- `rx_pin` passes through a 2-flop synchronizer (sync flops reset to 1), giving `rx_s`. All decisions use `rx_s`.
- Counter `cnt` is 25 bits wide. `HALF` = floor(DELAY_FRAMES/2). `N` = BIT_PER_WORD+1.
- States:
  - **IDLE**: `busy`=0. On `rx_s`=0, go to START with `cnt` cleared.
  - **START**: at `cnt`+1 == HALF, sample `rx_s`.
    - 0: go to DATA with `cnt` and bit index cleared.
    - 1: false start; go to IDLE with no output.
  - **DATA**: at `cnt`+1 == DELAY_FRAMES, shift `rx_s` into shift register bit [idx], LSB first. After bit N-1, go to PARITY if enabled, otherwise STOP.
  - **PARITY**: (macro only) sample after one bit period and store the bit; go to STOP.
  - **STOP**: sample after one bit period.
    - `rx_s`=1 and parity OK: load `data` from the shift register, pulse `data_ready`, go to IDLE.
    - `rx_s`=1 and parity bad: pulse `parity_err`, leave `data` unchanged, go to IDLE.
    - `rx_s`=0: pulse `framing_err`, leave `data` unchanged, go to BREAK.
  - **BREAK**: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- Reset values: `data`=0, `data_ready`=0, `framing_err`=0, `parity_err`=0, `busy`=0, state IDLE, counters 0.
- Asserting reset mid-frame aborts the frame immediately with no output. After reset release the receiver resynchronizes on the next high→low transition.

## Timing
- Let T0 be the first cycle IDLE sees `rx_s`=0. `rx_pin` falls 2–3 cycles before T0.
- Start-bit sample: T0+HALF.
- Data bit i sample: T0+HALF+(i+1)·DELAY_FRAMES.
- Parity sample (if enabled): T0+HALF+(N+1)·DELAY_FRAMES.
- Stop sample: T0+HALF+(N+1+P)·DELAY_FRAMES, where P=1 with parity and 0 without.
- `data_ready`, `framing_err` and `parity_err` are registered. They are high exactly one cycle, the cycle after the stop sample. `data` is valid in that same cycle and stays stable afterward.
- Only one of the three pulses fires per frame; all stay 0 on a false start.
- The return to IDLE happens mid-stop-bit. A start edge arriving ≥ HALF cycles after the stop sample is caught, so back-to-back frames with no idle gap are received.
- `busy` rises at T0+1 and falls when the state returns to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - One even-parity bit follows the data bits.
  - Parity check: XOR of data bits and parity bit must be 0; on mismatch `parity_err` pulses and `data` is not updated.
  - Frame = start + N + parity + stop.
- Not defined:
  - No PARITY state.
  - `parity_err` is tied to 0; the port is kept.
  - Frame = start + N + stop.

## Test plan
All scenarios use DELAY_FRAMES=16 and BIT_PER_WORD=7.
- Send 0xA5, 8N1 → one `data_ready` pulse; `data`=0xA5 at T0+8+9·16; no error pulses.
- Hold `rx_pin` low for 5 cycles, then high → no pulses; `busy` returns to 0 by T0+9; state IDLE.
- Send 0x3C with stop bit 0, line low for 3 bit times → one `framing_err` pulse; `data` keeps its previous value; no new frame accepted until the line returns high.
- Send 0x00 then 0xFF back-to-back with no idle → two `data_ready` pulses, exactly 160 cycles apart, with `data`=0x00 then 0xFF.
- Assert `rst_n` low during bit 3 of 0x55, release, then send 0x81 → no pulse for 0x55; `data`=0x81 with one `data_ready` pulse.
- With `UART_RX_PARITY_EN`: send 0x07 with parity 1 → `data`=0x07 and `data_ready` pulse. Send 0x07 with parity 0 → one `parity_err` pulse; `data` unchanged.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with one-cycle data/error pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx #(
  parameter int DELAY_FRAMES = 2812,
  parameter int BIT_PER_WORD = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_pin,
  output logic [BIT_PER_WORD:0]   data,
  output logic                    data_ready,
  output logic                    framing_err,
  output logic                    parity_err,
  output logic                    busy
);

  localparam int IDX_W = (BIT_PER_WORD > 0) ? $clog2(BIT_PER_WORD + 1) : 1;
  localparam logic [24:0] HALF = 25'(DELAY_FRAMES / 2);
  localparam logic [24:0] FULL = 25'(DELAY_FRAMES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIT_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                state;
  logic [1:0]            sync;
  logic                  rx_s;
  logic [24:0]           cnt;
  logic [IDX_W-1:0]      idx;
  logic [BIT_PER_WORD:0] shreg;

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  logic parity_ok;
  assign parity_ok = ~^{shreg, parity_bit};
`else
  assign parity_err = 1'b0;
`endif

  // Sync flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx_pin};
  end

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data        <= '0;
      data_ready  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit  <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      data_ready  <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt + 25'd1 == HALF) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 25'd1;
          end
        end
        ST_DATA: begin
          if (cnt + 25'd1 == FULL) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + 25'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt + 25'd1 == FULL) begin
            cnt        <= '0;
            parity_bit <= rx_s;
            state      <= ST_STOP;
          end else begin
            cnt <= cnt + 25'd1;
          end
        end
`endif
        // Leaving mid-stop-bit lets a following start edge be caught with no idle gap.
        ST_STOP: begin
          if (cnt + 25'd1 == FULL) begin
            cnt <= '0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (!parity_ok) begin
                parity_err <= 1'b1;
              end else begin
                data       <= shreg;
                data_ready <= 1'b1;
              end
`else
              data       <= shreg;
              data_ready <= 1'b1;
`endif
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              framing_err <= 1'b1;
              state       <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 25'd1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames (hand + random) scored by a
// frame-level model, plus hand sequences for false start, break, back-to-back and reset.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int D    = 16;
  localparam int BPW  = 7;
  localparam int N    = BPW + 1;
  localparam int HALF = D / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Pin edge to visible pulse: 3 sync/detect cycles, half a bit, then the remaining bit periods.
  localparam int LAT    = 3 + HALF + (N + 1 + P) * D;
  localparam int FRAME  = (N + 2 + P) * D;

  localparam int KR   = 0;
  localparam int KFR  = 1;
  localparam int KPAR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] data;
  logic       data_ready;
  logic       framing_err;
  logic       parity_err;
  logic       busy;

  int cyc;
  int n_checks = 0;
  int n_errors = 0;
  int overlap_cnt = 0;
  int rd = 0;

  typedef struct {
    int         kind;
    logic [7:0] dat;
    int         cyc;
  } event_t;
  event_t evq[$];

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         flip;
    int         gap;
    int         exp_kind;
    logic [7:0] exp_dat;
  } frame_t;
  frame_t tbl[$];

  uart_rx #(.DELAY_FRAMES(D), .BIT_PER_WORD(BPW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin), .data(data),
    .data_ready(data_ready), .framing_err(framing_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (int'(data_ready) + int'(framing_err) + int'(parity_err) > 1) overlap_cnt++;
    if (data_ready)  evq.push_back('{kind: KR,   dat: data, cyc: cyc});
    if (framing_err) evq.push_back('{kind: KFR,  dat: data, cyc: cyc});
    if (parity_err)  evq.push_back('{kind: KPAR, dat: data, cyc: cyc});
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete, required finish before 2 ms");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: outcome depends only on the stop level and parity correctness.
  function automatic int model_kind(input bit stop, input bit flip);
    if (!stop) return KFR;
    if (P == 1 && flip) return KPAR;
    return KR;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit flip,
                            input int hold, output int start);
    start  = cyc;
    rx_pin = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rx_pin = d[i];
      repeat (D) @(negedge clk);
    end
    if (P == 1) begin
      rx_pin = (^d) ^ flip;
      repeat (D) @(negedge clk);
    end
    rx_pin = stop;
    repeat (D + hold) @(negedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic applyStimulus(input frame_t f, output int start);
    send_frame(f.d, f.stop, f.flip, 0, start);
    repeat (f.gap) @(negedge clk);
  endtask

  task automatic expect_event(input string name, input int kind, input logic [7:0] dat,
                              input int ecyc);
    event_t ev;
    checkOutput({name, " pulse count"}, evq.size() - rd, 1);
    if (evq.size() > rd) begin
      ev = evq[rd];
      checkOutput({name, " pulse kind"}, ev.kind, kind);
      checkOutput({name, " pulse cycle"}, ev.cyc, ecyc);
      if (kind == KR) checkOutput({name, " data at pulse"}, ev.dat, dat);
    end
    rd = evq.size();
  endtask

  initial begin
    int st, st2;
    logic [7:0] md;
    frame_t f;

    // Hand-written rows with constant expectations.
    tbl.push_back('{d: 8'hA5, stop: 1, flip: 0, gap: 5, exp_kind: KR,  exp_dat: 8'hA5});
    tbl.push_back('{d: 8'h3C, stop: 0, flip: 0, gap: 6, exp_kind: KFR, exp_dat: 8'hA5});
`ifdef UART_RX_PARITY_EN
    tbl.push_back('{d: 8'h07, stop: 1, flip: 0, gap: 3, exp_kind: KR,   exp_dat: 8'h07});
    tbl.push_back('{d: 8'h07, stop: 1, flip: 1, gap: 3, exp_kind: KPAR, exp_dat: 8'h07});
`endif
    md = tbl[tbl.size() - 1].exp_dat;
    for (int i = 0; i < 16; i++) begin
      f.d        = 8'($urandom_range(0, 255));
      f.stop     = ($urandom_range(0, 4) != 0);
      f.flip     = ($urandom_range(0, 3) == 0);
      f.gap      = f.stop ? $urandom_range(0, 12) : $urandom_range(4, 12);
      f.exp_kind = model_kind(f.stop, f.flip);
      if (f.exp_kind == KR) md = f.d;
      f.exp_dat  = md;
      tbl.push_back(f);
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset data", data, 0);
    checkOutput("reset data_ready", data_ready, 0);
    checkOutput("reset framing_err", framing_err, 0);
    checkOutput("reset parity_err", parity_err, 0);
    checkOutput("reset busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i], st);
      expect_event($sformatf("frame%0d", i), tbl[i].exp_kind, tbl[i].exp_dat, st + LAT);
      checkOutput($sformatf("frame%0d data port", i), data, tbl[i].exp_dat);
    end
    repeat (20) @(negedge clk);

    // False start: 5 low cycles must leave no trace.
    st = cyc;
    rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("false start busy high", busy, 1);
    @(negedge clk);
    rx_pin = 1'b1;
    while (cyc < st + 12) @(negedge clk);
    checkOutput("false start busy low", busy, 0);
    repeat (200) @(negedge clk);
    checkOutput("false start no pulses", evq.size() - rd, 0);
    checkOutput("false start data kept", data, md);

    // Stop bit low, line held low for extra bit times: one framing pulse, nothing else.
    send_frame(8'h3C, 1'b0, 1'b0, 2 * D, st);
    checkOutput("break busy while low", busy, 1);
    expect_event("break", KFR, md, st + LAT);
    repeat (6) @(negedge clk);
    checkOutput("break busy after high", busy, 0);
    checkOutput("break data kept", data, md);
    repeat (10) @(negedge clk);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, 0, st);
    send_frame(8'hFF, 1'b1, 1'b0, 0, st2);
    repeat (4) @(negedge clk);
    checkOutput("b2b pulse count", evq.size() - rd, 2);
    if (evq.size() - rd >= 2) begin
      checkOutput("b2b first kind", evq[rd].kind, KR);
      checkOutput("b2b first data", evq[rd].dat, 8'h00);
      checkOutput("b2b first cycle", evq[rd].cyc, st + LAT);
      checkOutput("b2b second kind", evq[rd + 1].kind, KR);
      checkOutput("b2b second data", evq[rd + 1].dat, 8'hFF);
      checkOutput("b2b spacing", evq[rd + 1].cyc - evq[rd].cyc, FRAME);
    end
    rd = evq.size();
    md = 8'hFF;
    checkOutput("b2b data port", data, md);
    repeat (10) @(negedge clk);

    // Reset in the middle of bit 3 of 0x55 aborts the frame.
    rx_pin = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_pin = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat ((i == 3) ? HALF : D) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midframe reset busy", busy, 0);
    checkOutput("midframe reset data", data, 0);
    rx_pin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    checkOutput("midframe reset no pulses", evq.size() - rd, 0);
    send_frame(8'h81, 1'b1, 1'b0, 0, st);
    repeat (10) @(negedge clk);
    expect_event("after reset", KR, 8'h81, st + LAT);
    checkOutput("after reset data port", data, 8'h81);

    repeat (50) @(negedge clk);
    checkOutput("no stray pulses", evq.size() - rd, 0);
    checkOutput("pulse exclusivity", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
